// File: rtl/sa_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sa_ctrl_pkg
// Shared definitions for the systolic-array load controller:
//   state_e     - controller FSM state encoding (IDLE / LOAD / DONE)
//   MODE_W      - request mode value for a weight load
//   MODE_PS     - request mode value for a partial-sum load
//   LOAD_CNT_W  - width of the completed-request counter output
// -----------------------------------------------------------------------------
package sa_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_W  = 1'b0;
  localparam logic MODE_PS = 1'b1;

  localparam int LOAD_CNT_W = 16;

endpackage : sa_ctrl_pkg

// File: rtl/sa_row_onehot.sv
// -----------------------------------------------------------------------------
// sa_row_onehot
// Converts a binary row index into a one-hot row select, gated by an enable.
// Ports:
//   idx_i     [IDX_W] - binary row index (expected < ROWS)
//   en_i              - when low the output is all zeros
//   row_sel_o [ROWS]  - one-hot row select
// -----------------------------------------------------------------------------
module sa_row_onehot #(
  parameter int ROWS  = 4,
  parameter int IDX_W = 3
) (
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [ROWS-1:0]  row_sel_o
);

  // NOTE: every bit gets a default before the loop so no latch is inferred.
  always_comb begin
    row_sel_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (en_i && (idx_i == IDX_W'(r))) row_sel_o[r] = 1'b1;
    end
  end

endmodule : sa_row_onehot

// File: rtl/sa_load_ctrl.sv
// -----------------------------------------------------------------------------
// sa_load_ctrl
// Sequences row-by-row loads of a systolic array. A request (mode + length)
// is accepted in IDLE, then one row beat is issued per non-stalled cycle in
// LOAD, followed by a one-cycle DONE pulse. abort returns to IDLE at once.
//
// Optional feature: define SA_LOAD_CTRL_STATS_EN to enable a saturating
// completed-request counter on load_count; otherwise load_count is tied to 0.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid/ready   - request handshake (ready only in IDLE)
//   req_mode          - MODE_W (weights) or MODE_PS (partial sums)
//   req_len [LEN_W]   - rows to load; 0 is treated as 1, >ROWS as ROWS
//   stall             - freezes beat progress while high
//   abort             - ends the current request, or blocks acceptance in IDLE
//   load_en           - a row beat is issued this cycle
//   row_sel [ROWS]    - one-hot row of the current beat, zero otherwise
//   ctrl_out          - 1 selects the weight path during a weight request
//   busy              - LOAD or DONE
//   done              - single-cycle completion pulse
//   load_count [16]   - completed-request counter
// -----------------------------------------------------------------------------
module sa_load_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int LEN_W = $clog2(ROWS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  stall,
  input  logic                  abort,
  output logic                  load_en,
  output logic [ROWS-1:0]       row_sel,
  output logic                  ctrl_out,
  output logic                  busy,
  output logic                  done,
  output logic [LOAD_CNT_W-1:0] load_count
);

  localparam logic [LEN_W-1:0] ROWS_L = LEN_W'(ROWS);
  localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_clamped;
  logic             last_beat;

  // Length is clamped at acceptance so idx can never pass ROWS-1.
  always_comb begin
    len_clamped = req_len;
    if (req_len == '0)        len_clamped = ONE_L;
    else if (req_len > ROWS_L) len_clamped = ROWS_L;
  end

  // idx+1 fits in LEN_W because idx <= ROWS-1.
  assign last_beat = ((idx_q + ONE_L) == len_q);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    len_d     = len_q;
    idx_d     = idx_q;
    req_ready = 1'b0;
    load_en   = 1'b0;
    ctrl_out  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !abort) begin
          state_d = ST_LOAD;
          mode_d  = req_mode;
          len_d   = len_clamped;
          idx_d   = '0;
        end
      end

      ST_LOAD: begin
        busy     = 1'b1;
        ctrl_out = (mode_q == MODE_W);
        // A beat in the abort cycle is still issued; only progress stops.
        load_en  = !stall;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!stall) begin
          if (last_beat) state_d = ST_DONE;
          else           idx_d   = idx_q + ONE_L;
        end
      end

      ST_DONE: begin
        busy     = 1'b1;
        ctrl_out = (mode_q == MODE_W);
        done     = !abort;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_W;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  sa_row_onehot #(
    .ROWS  (ROWS),
    .IDX_W (LEN_W)
  ) u_row_onehot (
    .idx_i     (idx_q),
    .en_i      (load_en),
    .row_sel_o (row_sel)
  );

`ifdef SA_LOAD_CTRL_STATS_EN
  logic [LOAD_CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones; aborted requests never raise done.
  always_comb begin
    cnt_d = cnt_q;
    if (done && (cnt_q != '1)) cnt_d = cnt_q + LOAD_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign load_count = cnt_q;
`else
  assign load_count = '0;
`endif

endmodule : sa_load_ctrl

// File: tb/tb_sa_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sa_load_ctrl
// Directed bench for sa_load_ctrl with ROWS=4. Inputs change 1 time unit
// after the rising edge; outputs are compared one unit later, well away from
// the next edge. Observed outputs are packed as
// {req_ready, load_en, row_sel[3:0], ctrl_out, busy, done}.
// -----------------------------------------------------------------------------
module tb_sa_load_ctrl;
  import sa_ctrl_pkg::*;

  localparam int ROWS  = 4;
  localparam int LEN_W = 3;

`ifdef SA_LOAD_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_mode = MODE_W;
  logic [LEN_W-1:0] req_len = '0;
  logic             stall = 1'b0;
  logic             abort = 1'b0;
  logic             load_en;
  logic [ROWS-1:0]  row_sel;
  logic             ctrl_out;
  logic             busy;
  logic             done;
  logic [15:0]      load_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_cnt  = 0;
  logic [8:0]  obs;
  logic [8:0]  exp_v;
  logic [15:0] exp_lc;

  sa_load_ctrl #(.ROWS(ROWS), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_len    (req_len),
    .stall      (stall),
    .abort      (abort),
    .load_en    (load_en),
    .row_sel    (row_sel),
    .ctrl_out   (ctrl_out),
    .busy       (busy),
    .done       (done),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  assign obs = {req_ready, load_en, row_sel, ctrl_out, busy, done};

  function automatic logic [8:0] ev(input logic rdy, input logic le, input logic [3:0] rs,
                                    input logic co, input logic bz, input logic dn);
    return {rdy, le, rs, co, bz, dn};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    exp_v = ev(1, 0, 4'b0000, 0, 0, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rst_outputs: got %b want %b", obs, exp_v); end
    n_checks++;
    if (load_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", load_count); end
    // A request presented while reset is held must not be taken.
    req_valid = 1'b1; req_len = 3'd2;
    cyc();
    cyc();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_no_accept: busy got %b want 0", busy); end
    req_valid = 1'b0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_weight_full();
    req_valid = 1'b1; req_mode = MODE_W; req_len = 3'd4; #1;
    exp_v = ev(1, 0, 4'b0000, 0, 0, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL wt_accept: got %b want %b", obs, exp_v); end
    cyc(); req_valid = 1'b0; #1;
    for (int b = 0; b < 4; b++) begin
      exp_v = ev(0, 1, 4'(1 << b), 1, 1, 0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL wt_beat%0d: got %b want %b", b, obs, exp_v); end
      cyc();
    end
    exp_v = ev(0, 0, 4'b0000, 1, 1, 1);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL wt_done: got %b want %b", obs, exp_v); end
    exp_cnt++;
    cyc();
    exp_v = ev(1, 0, 4'b0000, 0, 0, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL wt_idle: got %b want %b", obs, exp_v); end
    exp_lc = STATS ? 16'(exp_cnt) : 16'd0;
    n_checks++;
    if (load_count !== exp_lc) begin n_fail++; $display("FAIL wt_count: got %0d want %0d", load_count, exp_lc); end
  endtask

  task automatic test_ps_len0();
    req_valid = 1'b1; req_mode = MODE_PS; req_len = 3'd0;
    cyc(); req_valid = 1'b0; #1;
    exp_v = ev(0, 1, 4'b0001, 0, 1, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ps_beat0: got %b want %b", obs, exp_v); end
    cyc();
    exp_v = ev(0, 0, 4'b0000, 0, 1, 1);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ps_done: got %b want %b", obs, exp_v); end
    exp_cnt++;
    cyc();
    exp_v = ev(1, 0, 4'b0000, 0, 0, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ps_idle: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_clamp_stall();
    req_valid = 1'b1; req_mode = MODE_W; req_len = 3'd7;
    cyc(); req_valid = 1'b0; #1;
    exp_v = ev(0, 1, 4'b0001, 1, 1, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cs_beat0: got %b want %b", obs, exp_v); end
    cyc();
    exp_v = ev(0, 1, 4'b0010, 1, 1, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cs_beat1: got %b want %b", obs, exp_v); end
    cyc();
    stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      exp_v = ev(0, 0, 4'b0000, 1, 1, 0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL cs_stall%0d: got %b want %b", s, obs, exp_v); end
      cyc();
    end
    stall = 1'b0; #1;
    exp_v = ev(0, 1, 4'b0100, 1, 1, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cs_beat2: got %b want %b", obs, exp_v); end
    cyc();
    exp_v = ev(0, 1, 4'b1000, 1, 1, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cs_beat3: got %b want %b", obs, exp_v); end
    cyc();
    exp_v = ev(0, 0, 4'b0000, 1, 1, 1);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL cs_done: got %b want %b", obs, exp_v); end
    exp_cnt++;
    cyc();
  endtask

  task automatic test_abort();
    req_valid = 1'b1; req_mode = MODE_W; req_len = 3'd4;
    cyc(); req_valid = 1'b0;
    cyc();
    abort = 1'b1; #1;
    exp_v = ev(0, 1, 4'b0010, 1, 1, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ab_beat1: got %b want %b", obs, exp_v); end
    cyc(); abort = 1'b0; #1;
    exp_v = ev(1, 0, 4'b0000, 0, 0, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ab_idle: got %b want %b", obs, exp_v); end
    exp_lc = STATS ? 16'(exp_cnt) : 16'd0;
    n_checks++;
    if (load_count !== exp_lc) begin n_fail++; $display("FAIL ab_count: got %0d want %0d", load_count, exp_lc); end
    // abort in IDLE blocks acceptance.
    req_valid = 1'b1; abort = 1'b1;
    cyc(); req_valid = 1'b0; abort = 1'b0; #1;
    exp_v = ev(1, 0, 4'b0000, 0, 0, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ab_in_idle: got %b want %b", obs, exp_v); end
    // abort in DONE suppresses the pulse.
    req_valid = 1'b1; req_mode = MODE_PS; req_len = 3'd1;
    cyc(); req_valid = 1'b0;
    cyc();
    abort = 1'b1; #1;
    exp_v = ev(0, 0, 4'b0000, 0, 1, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL ab_in_done: got %b want %b", obs, exp_v); end
    cyc(); abort = 1'b0; #1;
    exp_lc = STATS ? 16'(exp_cnt) : 16'd0;
    n_checks++;
    if (load_count !== exp_lc) begin n_fail++; $display("FAIL ab_done_count: got %0d want %0d", load_count, exp_lc); end
  endtask

  task automatic test_reset_mid_load();
    req_valid = 1'b1; req_mode = MODE_W; req_len = 3'd4;
    cyc(); req_valid = 1'b0;
    cyc();
    rst = 1'b1; #1;
    exp_v = ev(1, 0, 4'b0000, 0, 0, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rml_outputs: got %b want %b", obs, exp_v); end
    n_checks++;
    if (load_count !== 16'd0) begin n_fail++; $display("FAIL rml_count: got %0d want 0", load_count); end
    exp_cnt = 0;
    cyc();
    rst = 1'b0; req_valid = 1'b1; req_mode = MODE_W; req_len = 3'd2;
    cyc(); req_valid = 1'b0; #1;
    exp_v = ev(0, 1, 4'b0001, 1, 1, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rml_beat0: got %b want %b", obs, exp_v); end
    cyc();
    exp_v = ev(0, 1, 4'b0010, 1, 1, 0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL rml_beat1: got %b want %b", obs, exp_v); end
    cyc();
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL rml_done: got %b want 1", done); end
    cyc();
  endtask

  task automatic test_stats();
    rst = 1'b1; #1; cyc(); rst = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_mode = MODE_PS; req_len = 3'd1;
      cyc(); req_valid = 1'b0;
      for (int c = 0; c < 10 && done !== 1'b1; c++) cyc();
      n_checks++;
      if (done !== 1'b1) begin n_fail++; $display("FAIL st_done%0d: got %b want 1 (timeout)", k, done); end
      exp_cnt++;
      cyc();
    end
    req_valid = 1'b1; req_mode = MODE_W; req_len = 3'd3;
    cyc(); req_valid = 1'b0;
    abort = 1'b1;
    cyc(); abort = 1'b0;
    cyc(); cyc();
    exp_lc = STATS ? 16'(exp_cnt) : 16'd0;
    n_checks++;
    if (load_count !== exp_lc) begin n_fail++; $display("FAIL st_count: got %0d want %0d", load_count, exp_lc); end
  endtask

  initial begin
    test_reset();
    test_weight_full();
    test_ps_len0();
    test_clamp_stall();
    test_abort();
    test_reset_mid_load();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sa_load_ctrl

// File: doc/sa_load_ctrl.md
SA_LOAD_CTRL -- requirements
Module: sa_load_ctrl

Interface
REQ-001 Parameter ROWS, default 4, number of systolic-array rows to be loaded (legal 2..64).
REQ-002 Parameter LEN_W, default $clog2(ROWS+1), width of the length field.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  load request present.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_mode  input  1  0 = weight load, 1 = partial-sum load.
REQ-008 req_len  input  LEN_W  rows to load in this request.
REQ-009 stall  input  1  downstream not ready; freezes beat progress.
REQ-010 abort  input  1  terminate the current request.
REQ-011 load_en  output  1  a row load beat is issued this cycle.
REQ-012 row_sel  output  ROWS  one-hot row being loaded; zero when load_en=0.
REQ-013 ctrl_out  output  1  1 = weight path selected, 0 = partial-sum path.
REQ-014 busy  output  1  request in progress (LOAD or DONE state).
REQ-015 done  output  1  single-cycle completion pulse.
REQ-016 load_count  output  16  completed-request counter (see Configuration).

Function
REQ-017 States: IDLE, LOAD, DONE; encoding is an enum held in the shared package.
REQ-018 IDLE: req_ready=1; on req_valid=1, latch mode and length and go to LOAD next cycle.
REQ-019 Length rule: req_len=0 latches as 1; req_len>ROWS latches as ROWS.
REQ-020 LOAD: with stall=0, issue one beat per cycle (load_en=1, row_sel=1<<idx), where idx starts at 0 and increments per beat.
REQ-021 LOAD with stall=1: load_en=0, row_sel=0, idx held, no timeout.
REQ-022 After the beat with idx = latched length-1, go to DONE next cycle.
REQ-023 ctrl_out = 1 during LOAD and DONE of a weight request, 0 otherwise.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; req_ready=0 in LOAD and DONE.
REQ-025 Latency with no stall: accept at cycle T, beats T+1..T+len, done at T+len+1, req_ready again at T+len+2.
REQ-026 abort=1 in LOAD or DONE: go to IDLE next cycle; no done pulse; the current cycle's beat, if any, is still issued.
REQ-027 abort=1 in IDLE overrides req_valid: no request is accepted.
REQ-028 idx never exceeds ROWS-1, so row_sel has no wrap-around.

Reset
REQ-029 rst=1 forces IDLE immediately, including mid-request.
REQ-030 rst=1 clears idx, latched mode and length, and load_count.
REQ-031 Output values during reset: req_ready=1, load_en=0, row_sel=0, ctrl_out=0, busy=0, done=0, load_count=0.

Configuration
REQ-032 Macro SA_LOAD_CTRL_STATS_EN defined: load_count increments on each done pulse and saturates at 16'hFFFF; aborted requests do not count.
REQ-033 Macro SA_LOAD_CTRL_STATS_EN undefined: load_count is tied to 0, with no counter flops.

Structure
REQ-034 Package sa_ctrl_pkg holds the state enum, the mode constants MODE_W=0 and MODE_PS=1, and the load_count width constant.
REQ-035 One sub-module, sa_row_onehot, converts idx to one-hot row_sel with an enable gate.

Verification
REQ-036 ROWS=4: weight request with len=4 and no stall -> row_sel 0001,0010,0100,1000 in T+1..T+4, ctrl_out=1, done at T+5.
REQ-037 Partial-sum request with len=0 -> one beat (row_sel=0001, ctrl_out=0), done at T+2.
REQ-038 len=7 with ROWS=4 -> exactly 4 beats; stall high at beat 2 for 3 cycles -> beat 2 repeats after the stall, done at T+8.
REQ-039 abort in the cycle of beat 1 -> IDLE next cycle, no done, load_count unchanged, req_ready=1.
REQ-040 rst asserted mid-LOAD -> all outputs at reset values within the same cycle; a new request is accepted the first cycle after release.
REQ-041 With SA_LOAD_CTRL_STATS_EN defined, 3 completed requests plus 1 aborted request -> load_count=3.
